multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// Control FSM for a multi-cycle MIPS-subset datapath. One state register
// walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The instruction fields
// are captured when the fetch completes, and every later decode uses that
// captured copy.
//
// Build option: CTRL_ILLEGAL_HALT_EN
//   defined   : an unsupported opcode sends DECODE to HALT, which only reset leaves
//   undefined : an unsupported opcode is a NOP (DECODE -> FETCH), halted tied 0
//
// Ports
//   clk, rstn           clock, async active-low reset
//   opCode, func, zero  instruction fields and ALU zero flag
//   memReady            memory access completes this cycle
//   pcWrite, irWrite, memRead, memWrite, regWrite   strobes
//   pcSrc, regDst, regSrc, ALUSrc, ALUOp            datapath selects
//   state, halted       debug state, HALT indicator
//
// state  | meaning
// FETCH  | read instruction, PC+4 on memReady
// DECODE | register read, opcode check
// EXEC   | ALU op / branch / jump resolution
// MEM    | lw read or sw write, held until memReady
// WB     | register-file write
// HALT   | illegal opcode trap (option only)
module multi_cycle_controller (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opCode,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       irWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] pcSrc,
    output logic [1:0] regDst,
    output logic [1:0] regSrc,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
`ifdef CTRL_ILLEGAL_HALT_EN
        S_WB     = 3'd4,
        S_HALT   = 3'd5
`else
        S_WB     = 3'd4
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [5:0] r_fn;

    logic w_rtype, w_jr, w_addi, w_andi, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_legal;
    logic w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;

    assign w_jr    = (r_op == OP_RTYPE) && (r_fn == FN_JR);
    assign w_rtype = (r_op == OP_RTYPE) && (r_fn != FN_JR);
    assign w_addi  = (r_op == OP_ADDI);
    assign w_andi  = (r_op == OP_ANDI);
    assign w_lw    = (r_op == OP_LW);
    assign w_sw    = (r_op == OP_SW);
    assign w_beq   = (r_op == OP_BEQ);
    assign w_bne   = (r_op == OP_BNE);
    assign w_j     = (r_op == OP_J);
    assign w_jal   = (r_op == OP_JAL);
    assign w_legal = w_rtype | w_jr | w_addi | w_andi | w_lw | w_sw |
                     w_beq | w_bne | w_j | w_jal;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_FETCH;
            r_op    <= 6'd0;
            r_fn    <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && memReady) begin
                r_op <= opCode;
                r_fn <= func;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        pcSrc       = 2'd0;
        regDst      = 2'd0;
        regSrc      = 2'd0;
        ALUSrc      = 1'b0;
        ALUOp       = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (memReady) begin
                    w_pc_write = 1'b1;
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal)
                    w_next = S_EXEC;
                else
`ifdef CTRL_ILLEGAL_HALT_EN
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
            end
            S_EXEC: begin
                w_next = S_FETCH;
                if (w_rtype) begin
                    ALUOp  = 2'b10;
                    w_next = S_WB;
                end else if (w_addi || w_andi) begin
                    ALUSrc = 1'b1;
                    ALUOp  = w_andi ? 2'b11 : 2'b00;
                    w_next = S_WB;
                end else if (w_lw || w_sw) begin
                    ALUSrc = 1'b1;
                    w_next = S_MEM;
                end else if (w_beq || w_bne) begin
                    ALUOp      = 2'b01;
                    pcSrc      = 2'd1;
                    w_pc_write = w_beq ? zero : ~zero;
                end else if (w_j || w_jal) begin
                    pcSrc      = 2'd2;
                    w_pc_write = 1'b1;
                    if (w_jal) begin
                        // PC was already advanced in FETCH, so it is the link value
                        w_reg_write = 1'b1;
                        regDst      = 2'd2;
                        regSrc      = 2'd0;
                    end
                end else if (w_jr) begin
                    pcSrc      = 2'd3;
                    w_pc_write = 1'b1;
                end
            end
            S_MEM: begin
                if (w_lw) w_mem_read  = 1'b1;
                else      w_mem_write = 1'b1;
                if (memReady) w_next = w_lw ? S_WB : S_FETCH;
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
                if (w_rtype) begin
                    // ALU keeps decoding func so the captured result stays valid
                    regDst = 2'd1;
                    regSrc = 2'd2;
                    ALUOp  = 2'b10;
                end else if (w_lw) begin
                    regSrc = 2'd1;
                end else begin
                    regSrc = 2'd2;
                end
            end
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT: w_next = S_HALT;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are gated by rstn so they drop the instant reset asserts,
    // including the memRead that FETCH would otherwise drive.
    assign pcWrite  = rstn & w_pc_write;
    assign irWrite  = rstn & w_ir_write;
    assign memRead  = rstn & w_mem_read;
    assign memWrite = rstn & w_mem_write;
    assign regWrite = rstn & w_reg_write;
    assign state    = r_state;

`ifdef CTRL_ILLEGAL_HALT_EN
    assign halted = (r_state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] opCode, func;
    logic       zero, memReady;
    logic       pcWrite, irWrite, memRead, memWrite, regWrite;
    logic [1:0] pcSrc, regDst, regSrc, ALUOp;
    logic       ALUSrc;
    logic [2:0] state;
    logic       halted;

    multi_cycle_controller dut (
        .clk(clk), .rstn(rstn), .opCode(opCode), .func(func), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .irWrite(irWrite),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .pcSrc(pcSrc), .regDst(regDst), .regSrc(regSrc), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    // vector: {state[3], pcW,irW,mRd,mWr,rW, pcSrc[2], regDst[2], regSrc[2], ALUSrc, ALUOp[2], halted}
    localparam logic [17:0] RST_V  = 18'd0;
    localparam logic [17:0] F_WAIT = {3'd0, 5'b00100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] F_DONE = {3'd0, 5'b11100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] DEC    = {3'd1, 15'd0};
    localparam logic [17:0] R_EX   = {3'd2, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b0, 2'b10, 1'b0};
    localparam logic [17:0] R_WB   = {3'd4, 5'b00001, 2'd0, 2'd1, 2'd2, 1'b0, 2'b10, 1'b0};
    localparam logic [17:0] AI_EX  = {3'd2, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'b00, 1'b0};
    localparam logic [17:0] AN_EX  = {3'd2, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'b11, 1'b0};
    localparam logic [17:0] I_WB   = {3'd4, 5'b00001, 2'd0, 2'd0, 2'd2, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] LS_EX  = {3'd2, 5'b00000, 2'd0, 2'd0, 2'd0, 1'b1, 2'b00, 1'b0};
    localparam logic [17:0] LW_MEM = {3'd3, 5'b00100, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] LW_WB  = {3'd4, 5'b00001, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] SW_MEM = {3'd3, 5'b00010, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] BR_T   = {3'd2, 5'b10000, 2'd1, 2'd0, 2'd0, 1'b0, 2'b01, 1'b0};
    localparam logic [17:0] BR_N   = {3'd2, 5'b00000, 2'd1, 2'd0, 2'd0, 1'b0, 2'b01, 1'b0};
    localparam logic [17:0] J_EX   = {3'd2, 5'b10000, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] JAL_EX = {3'd2, 5'b10001, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] JR_EX  = {3'd2, 5'b10000, 2'd3, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0};
    localparam logic [17:0] HALT_V = {3'd5, 14'd0, 1'b1};

    localparam logic [5:0] JUNK = 6'h3f;

    typedef struct {
        logic [17:0] v;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [17:0] actual();
        return {state, pcWrite, irWrite, memRead, memWrite, regWrite,
                pcSrc, regDst, regSrc, ALUSrc, ALUOp, halted};
    endfunction

    task automatic compare(input logic [17:0] exp_v, input string nm);
        logic [17:0] a;
        a = actual();
        checks++;
        if (a !== exp_v) begin
            errors++;
            $display("FAIL %s: got %05h want %05h (state got %0d want %0d)",
                     nm, a, exp_v, a[17:15], exp_v[17:15]);
        end
    endtask

    // monitor: one expected vector per stimulated cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare(e.v, e.nm);
            end
        end
    end

    // called at posedge+1; pushes the expectation for this cycle, then advances
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic mr, input logic [17:0] e, input string nm);
        exp_t x;
        opCode = op; func = fn; zero = z; memReady = mr;
        x.v = e; x.nm = nm;
        exp_q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input int waits, input string nm);
        for (int i = 0; i < waits; i++) cyc(JUNK, JUNK, 1'b0, 1'b0, F_WAIT, {nm, "_fwait"});
        cyc(op, fn, 1'b0, 1'b1, F_DONE, {nm, "_fetch"});
        cyc(JUNK, JUNK, 1'b0, 1'b1, DEC, {nm, "_decode"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rstn = 1'b0; opCode = 6'd0; func = 6'd0; zero = 1'b0; memReady = 1'b1;
        #2;
        compare(RST_V, "reset_state");
        memReady = 1'b0;
        #6 rstn = 1'b1;
        @(posedge clk); #1;

        cyc(JUNK, JUNK, 1'b0, 1'b0, F_WAIT, "post_reset_fetch");

        // add: 0,1,2,4,0
        fetch(6'd0, 6'h20, 0, "add");
        cyc(JUNK, JUNK, 1'b0, 1'b1, R_EX, "add_exec");
        cyc(JUNK, JUNK, 1'b0, 1'b1, R_WB, "add_wb");

        fetch(6'b001000, JUNK, 0, "addi");
        cyc(JUNK, JUNK, 1'b0, 1'b1, AI_EX, "addi_exec");
        cyc(JUNK, JUNK, 1'b0, 1'b1, I_WB, "addi_wb");

        fetch(6'b001100, JUNK, 0, "andi");
        cyc(JUNK, JUNK, 1'b0, 1'b1, AN_EX, "andi_exec");
        cyc(JUNK, JUNK, 1'b0, 1'b1, I_WB, "andi_wb");

        // lw: 2 fetch waits + 3 mem waits = 10 cycles
        fetch(6'b100011, JUNK, 2, "lw");
        cyc(JUNK, JUNK, 1'b0, 1'b1, LS_EX, "lw_exec");
        for (int i = 0; i < 3; i++) cyc(JUNK, JUNK, 1'b0, 1'b0, LW_MEM, "lw_memwait");
        cyc(JUNK, JUNK, 1'b0, 1'b1, LW_MEM, "lw_memdone");
        cyc(JUNK, JUNK, 1'b0, 1'b1, LW_WB, "lw_wb");

        fetch(6'b000100, JUNK, 0, "beq_z1");
        cyc(JUNK, JUNK, 1'b1, 1'b1, BR_T, "beq_z1_exec");
        fetch(6'b000101, JUNK, 0, "bne_z1");
        cyc(JUNK, JUNK, 1'b1, 1'b1, BR_N, "bne_z1_exec");
        fetch(6'b000100, JUNK, 0, "beq_z0");
        cyc(JUNK, JUNK, 1'b0, 1'b1, BR_N, "beq_z0_exec");
        fetch(6'b000101, JUNK, 0, "bne_z0");
        cyc(JUNK, JUNK, 1'b0, 1'b1, BR_T, "bne_z0_exec");

        fetch(6'b000010, JUNK, 0, "j");
        cyc(JUNK, JUNK, 1'b0, 1'b1, J_EX, "j_exec");
        fetch(6'b000011, JUNK, 0, "jal");
        cyc(JUNK, JUNK, 1'b0, 1'b1, JAL_EX, "jal_exec");
        fetch(6'b000000, 6'b001000, 0, "jr");
        cyc(JUNK, JUNK, 1'b0, 1'b1, JR_EX, "jr_exec");

        fetch(6'b101011, JUNK, 0, "sw");
        cyc(JUNK, JUNK, 1'b0, 1'b1, LS_EX, "sw_exec");
        cyc(JUNK, JUNK, 1'b0, 1'b1, SW_MEM, "sw_memdone");

        // sw with reset asserted during the MEM wait
        fetch(6'b101011, JUNK, 0, "sw2");
        cyc(JUNK, JUNK, 1'b0, 1'b1, LS_EX, "sw2_exec");
        cyc(JUNK, JUNK, 1'b0, 1'b0, SW_MEM, "sw2_memwait");
        cyc(JUNK, JUNK, 1'b0, 1'b0, SW_MEM, "sw2_memwait");
        memReady = 1'b0;
        #2 rstn = 1'b0;
        #1 compare(RST_V, "sw2_async_reset");
        @(posedge clk); #3;
        compare(RST_V, "reset_held");
        rstn = 1'b1;
        @(posedge clk); #1;
        cyc(JUNK, JUNK, 1'b0, 1'b0, F_WAIT, "after_reset_fetch");

        // unsupported opcode
        fetch(6'b111111, JUNK, 0, "illegal");
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int i = 0; i < 20; i++) cyc(JUNK, JUNK, 1'b0, 1'b1, HALT_V, "illegal_halt");
        memReady = 1'b0;
        #2 rstn = 1'b0;
        #1 compare(RST_V, "halt_reset");
        #4 rstn = 1'b1;
        @(posedge clk); #1;
        cyc(JUNK, JUNK, 1'b0, 1'b0, F_WAIT, "halt_exit_fetch");
`else
        cyc(JUNK, JUNK, 1'b0, 1'b0, F_WAIT, "illegal_nop_fetch");
`endif

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
